dispatch_stage_n: RTL and testbench
===================================

// Module: dispatch_stage_n
// PURPOSE
//  Parametrised successor to the 3-RS dispatch: routes renamed instrs to NUM_FU reservation-station channels through
//  one registered dispatch slot, so ready_in no longer depends combinationally on RS full flags. Owns the PRF busy
//  table with per-entry producer ROB tag, NUM_WAKE wakeup ports and same-cycle bypass. On mispredict, selectively
//  clears only the busy bits of squashed producers. Sits between rename and the RS/LSQ allocators.
// PARAMETERS
//  NUM_FU    3    RS channels; data_in.fu==k (1..NUM_FU) targets channel k-1; fu==0 -> ROB-only, no RS
//  MEM_FU    3    fu code whose channel also allocates an LSQ entry
//  NUM_PREG  128  physical registers; PREG_W = $clog2(NUM_PREG)
//  ROB_W     5    ROB tag width
//  NUM_WAKE  3    FU wakeup (writeback) ports
// PORTS
//  clk               in   1               clock
//  reset             in   1               synchronous, active-high
//  valid_in          in   1               rename output valid
//  data_in           in   rename_data     renamed instr (fields used: fu, Opcode, pd_new, ps1, ps2, rob_tag, pc)
//  ready_in          out  1               dispatch accepts data_in this cycle
//  rob_full          in   1               ROB cannot take another instr
//  rob_head          in   ROB_W           oldest ROB tag; reference point for age compares
//  lsq_full_in       in   1               LSQ cannot allocate
//  mispredict        in   1               flush pulse
//  mispredict_tag    in   ROB_W           ROB tag of the mispredicted branch
//  wake_valid        in   NUM_WAKE        per-port PRF write
//  wake_preg         in   NUM_WAKE*PREG_W preg written by each port
//  rs_full           in   NUM_FU          per-channel RS full
//  rs_alloc_valid    out  NUM_FU          one-hot: slot written into channel c this cycle
//  rs_alloc_data     out  rename_data     slot contents (shared bus to all channels)
//  rs_ps1_rdy        out  1               ps1 ready at allocation (table + same-cycle wakeup bypass)
//  rs_ps2_rdy        out  1               ps2 ready at allocation (table + same-cycle wakeup bypass)
//  lsq_alloc_valid   out  1               LSQ allocate pulse (load 0000011 / store 0100011 on MEM_FU)
//  lsq_rob_tag       out  ROB_W           ROB tag for LSQ entry; 0 when lsq_alloc_valid=0
//  lsq_pc            out  32              pc for LSQ entry; 0 when lsq_alloc_valid=0
// BEHAVIOUR
//  - Slot: one register {slot_v, slot_d}. Reset/mispredict: slot_v=0.
//    All outputs 0 while slot_v=0; busy table all ready (0) after reset.
//  - drain = slot_v && !mispredict && (fu==0 || (!rs_full[fu-1] && (fu!=MEM_FU || !is_ldst || !lsq_full_in))).
//  - ready_in = mispredict || (!rob_full && (!slot_v || drain)). Full-throughput: 1 instr/cycle when never blocked.
//  - Accept (valid_in && ready_in && !mispredict) loads slot next cycle; latency data_in -> rs_alloc_valid = 1 cycle.
//  - During mispredict: ready_in=1, input discarded, no alloc outputs, slot cleared.
//  - On drain: rs_alloc_valid[fu-1]=1 (none if fu==0 or fu>NUM_FU); lsq_alloc_valid if MEM_FU and is_ldst.
//  - psN_rdy = !busy[psN] || any(wake_valid[i] && wake_preg[i]==psN); p0 always ready.
//  - Busy mark on drain: busy[pd_new]=1, prod_tag[pd_new]=rob_tag, if pd_new!=0 and Opcode not store/branch(1100011).
//    Wakeup clears busy[wake_preg[i]]; mark and wakeup to same preg in same cycle: mark wins.
//  - Mispredict: clear busy[p] where age(prod_tag[p]) > age(mispredict_tag); age(t)=(t-rob_head) mod 2^ROB_W.
//    Older producers stay busy. Wakeups in the mispredict cycle still apply.
//  - Reset mid-operation: slot dropped, table all ready, next cycle ready_in = !rob_full.
// STRUCTURE
//  - types_pkg: rename_data (existing); add OPC_LOAD/OPC_STORE/OPC_BRANCH/OPC_JALR localparams and fu-code constants.
//  - One sub-module: prf_busy_table (busy bits, prod_tag, wakeup ports, bypassed read for ps1/ps2, selective flush).
//  - Slot/route logic stays in dispatch_stage_n.
// TESTING
//  - ALU add fu=1 pd_new=40, no stalls -> next cycle rs_alloc_valid=3'b001; busy[40]=1; consumer ps1=40 gets rs_ps1_rdy=0.
//  - rs_full[1]=1 with branch in slot -> slot holds; ready_in=0; valid_in/data_in ignored. Release -> alloc 3'b010 one cycle later.
//  - Load fu=3 with lsq_full_in=1 -> no alloc. Clear -> rs_alloc_valid=3'b100, lsq_alloc_valid=1, lsq_rob_tag=rob_tag.
//  - busy[17]=1; wake_preg[2]=17 valid in same cycle consumer ps2=17 drains -> rs_ps2_rdy=1; busy[17]=0 next cycle.
//  - rob_head=30, producers tags 31/2/5 on pregs 50/51/52, mispredict_tag=1 -> busy[50]=1; busy[51]=0; busy[52]=0 (wrap).
//    Slot cleared; no alloc that cycle.
//  - Store fu=3 pd_new=9 drains -> busy[9] unchanged; mid-stream reset -> all outputs 0 next cycle; all pregs ready.

Source files
------------

// File: rtl/dispatch_stage_n_pkg.sv
// Shared types and constants for the dispatch stage and its PRF busy table.
package dispatch_stage_n_pkg;

    // Default configuration.
    localparam int unsigned NUM_FU_DEF   = 3;
    localparam int unsigned MEM_FU_DEF   = 3;
    localparam int unsigned NUM_WAKE_DEF = 3;

    // Physical register file and ROB sizing.
    localparam int unsigned NUM_PREG = 128;
    localparam int unsigned PREG_W   = $clog2(NUM_PREG);
    localparam int unsigned ROB_W    = 5;

    // Field widths of the renamed instruction.
    localparam int unsigned FU_W  = 3;
    localparam int unsigned OPC_W = 7;
    localparam int unsigned PC_W  = 32;

    // Opcodes that change how an instruction is routed or tracked.
    localparam logic [OPC_W-1:0] OPC_LOAD   = 7'b0000011;
    localparam logic [OPC_W-1:0] OPC_STORE  = 7'b0100011;
    localparam logic [OPC_W-1:0] OPC_BRANCH = 7'b1100011;
    localparam logic [OPC_W-1:0] OPC_JALR   = 7'b1100111;
    localparam logic [OPC_W-1:0] OPC_OP     = 7'b0110011;

    // fu codes: 0 is ROB-only, k in 1..NUM_FU targets channel k-1.
    localparam logic [FU_W-1:0] FU_NONE = 3'd0;
    localparam logic [FU_W-1:0] FU_MEM  = 3'd3;

    // Renamed instruction as delivered by rename.
    typedef struct packed {
        logic [FU_W-1:0]   fu;
        logic [OPC_W-1:0]  Opcode;
        logic [PREG_W-1:0] pd_new;
        logic [PREG_W-1:0] ps1;
        logic [PREG_W-1:0] ps2;
        logic [ROB_W-1:0]  rob_tag;
        logic [PC_W-1:0]   pc;
    } rename_data;

    // Distance of a ROB tag from the head; larger means younger.
    function automatic logic [ROB_W-1:0] rob_age(input logic [ROB_W-1:0] tag,
                                                 input logic [ROB_W-1:0] head);
        return ROB_W'(tag - head);
    endfunction

    // Memory ops need an LSQ entry in addition to their RS entry.
    function automatic logic is_ldst(input logic [OPC_W-1:0] opc);
        return (opc == OPC_LOAD) || (opc == OPC_STORE);
    endfunction

    // jalr is control flow but still writes rd; only stores and branches lack a destination.
    function automatic logic writes_dest(input logic [OPC_W-1:0] opc);
        return (opc == OPC_JALR) || ((opc != OPC_STORE) && (opc != OPC_BRANCH));
    endfunction

endpackage

// File: rtl/dispatch_stage_n_prf_busy_table.sv
// PRF busy table: per-preg busy bit and producer ROB tag, wakeup ports,
// bypassed source readiness and selective clear of squashed producers.
module prf_busy_table
    import dispatch_stage_n_pkg::*;
#(
    parameter int unsigned NUM_WAKE = NUM_WAKE_DEF
) (
    input  logic                       clk,
    input  logic                       reset,
    // destination mark from the draining slot
    input  logic                       mark_i,
    input  logic [PREG_W-1:0]          mark_preg_i,
    input  logic [ROB_W-1:0]           mark_tag_i,
    // writeback wakeups
    input  logic [NUM_WAKE-1:0]        wake_valid_i,
    input  logic [NUM_WAKE*PREG_W-1:0] wake_preg_i,
    // selective flush
    input  logic                       flush_i,
    input  logic [ROB_W-1:0]           flush_tag_i,
    input  logic [ROB_W-1:0]           rob_head_i,
    // source readiness lookups
    input  logic [PREG_W-1:0]          rd_ps1_i,
    input  logic [PREG_W-1:0]          rd_ps2_i,
    output logic                       ps1_rdy_c_o,
    output logic                       ps2_rdy_c_o
);

    logic [NUM_PREG-1:0] busy_q;
    logic [NUM_PREG-1:0] busy_d;
    logic [ROB_W-1:0]    tag_q [NUM_PREG];
    logic [ROB_W-1:0]    tag_d [NUM_PREG];
    logic [ROB_W-1:0]    flush_age_c;
    logic                ps1_hit_c;
    logic                ps2_hit_c;

    // Next table state: wakeups and flush clear first, a new mark overrides both.
    always_comb begin
        busy_d      = busy_q;
        tag_d       = tag_q;
        flush_age_c = rob_age(flush_tag_i, rob_head_i);

        for (int unsigned i = 0; i < NUM_WAKE; i++) begin
            if (wake_valid_i[i]) begin
                busy_d[wake_preg_i[i*PREG_W +: PREG_W]] = 1'b0;
            end
        end

        if (flush_i) begin
            for (int unsigned p = 0; p < NUM_PREG; p++) begin
                if (rob_age(tag_q[p], rob_head_i) > flush_age_c) begin
                    busy_d[PREG_W'(p)] = 1'b0;
                end
            end
        end

        if (mark_i) begin
            busy_d[mark_preg_i] = 1'b1;
            tag_d[mark_preg_i]  = mark_tag_i;
        end
    end

    // Table registers; reset leaves every preg ready.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q <= '0;
            for (int unsigned p = 0; p < NUM_PREG; p++) begin
                tag_q[p] <= '0;
            end
        end else begin
            busy_q <= busy_d;
            tag_q  <= tag_d;
        end
    end

    // Source readiness with same-cycle writeback bypass; p0 is hardwired ready.
    always_comb begin
        ps1_hit_c = 1'b0;
        ps2_hit_c = 1'b0;
        for (int unsigned i = 0; i < NUM_WAKE; i++) begin
            if (wake_valid_i[i] && (wake_preg_i[i*PREG_W +: PREG_W] == rd_ps1_i)) begin
                ps1_hit_c = 1'b1;
            end
            if (wake_valid_i[i] && (wake_preg_i[i*PREG_W +: PREG_W] == rd_ps2_i)) begin
                ps2_hit_c = 1'b1;
            end
        end
        ps1_rdy_c_o = (rd_ps1_i == '0) || !busy_q[rd_ps1_i] || ps1_hit_c;
        ps2_rdy_c_o = (rd_ps2_i == '0) || !busy_q[rd_ps2_i] || ps2_hit_c;
    end

endmodule

// File: rtl/dispatch_stage_n.sv
// Dispatch stage: one registered slot between rename and NUM_FU reservation
// station channels plus the LSQ, with the PRF busy table for source readiness.
module dispatch_stage_n
    import dispatch_stage_n_pkg::*;
#(
    parameter int unsigned NUM_FU   = NUM_FU_DEF,
    parameter int unsigned MEM_FU   = MEM_FU_DEF,
    parameter int unsigned NUM_WAKE = NUM_WAKE_DEF
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       valid_in,
    input  rename_data                 data_in,
    output logic                       ready_in,
    input  logic                       rob_full,
    input  logic [ROB_W-1:0]           rob_head,
    input  logic                       lsq_full_in,
    input  logic                       mispredict,
    input  logic [ROB_W-1:0]           mispredict_tag,
    input  logic [NUM_WAKE-1:0]        wake_valid,
    input  logic [NUM_WAKE*PREG_W-1:0] wake_preg,
    input  logic [NUM_FU-1:0]          rs_full,
    output logic [NUM_FU-1:0]          rs_alloc_valid,
    output rename_data                 rs_alloc_data,
    output logic                       rs_ps1_rdy,
    output logic                       rs_ps2_rdy,
    output logic                       lsq_alloc_valid,
    output logic [ROB_W-1:0]           lsq_rob_tag,
    output logic [PC_W-1:0]            lsq_pc
);

    logic              slot_v_q;
    logic              slot_v_d;
    rename_data        slot_d_q;
    rename_data        slot_d_d;

    logic [NUM_FU-1:0] chan_sel_c;
    logic              slot_mem_c;
    logic              drain_c;
    logic              accept_c;
    logic              mark_c;
    logic              ps1_rdy_c;
    logic              ps2_rdy_c;

    // Decode the slot's target channel and whether it also needs an LSQ entry.
    always_comb begin
        chan_sel_c = '0;
        for (int unsigned c = 0; c < NUM_FU; c++) begin
            if (slot_d_q.fu == FU_W'(c + 1)) begin
                chan_sel_c[c] = 1'b1;
            end
        end
        slot_mem_c = (slot_d_q.fu == FU_W'(MEM_FU)) && is_ldst(slot_d_q.Opcode);
    end

    // Slot leaves when its channel (and LSQ for memory ops) can take it; fu 0 leaves freely.
    always_comb begin
        drain_c  = slot_v_q && !mispredict
                   && !(|(chan_sel_c & rs_full))
                   && !(slot_mem_c && lsq_full_in);
        ready_in = mispredict || (!rob_full && (!slot_v_q || drain_c));
        accept_c = valid_in && ready_in && !mispredict;
        mark_c   = drain_c && (slot_d_q.pd_new != '0) && writes_dest(slot_d_q.Opcode);
    end

    // Slot next state: flush empties, accept refills, drain empties, otherwise hold.
    always_comb begin
        slot_v_d = slot_v_q;
        slot_d_d = slot_d_q;
        if (mispredict) begin
            slot_v_d = 1'b0;
        end else if (accept_c) begin
            slot_v_d = 1'b1;
            slot_d_d = data_in;
        end else if (drain_c) begin
            slot_v_d = 1'b0;
        end
    end

    // Slot register.
    always_ff @(posedge clk) begin
        if (reset) begin
            slot_v_q <= 1'b0;
            slot_d_q <= '0;
        end else begin
            slot_v_q <= slot_v_d;
            slot_d_q <= slot_d_d;
        end
    end

    prf_busy_table #(
        .NUM_WAKE (NUM_WAKE)
    ) u_busy (
        .clk          (clk),
        .reset        (reset),
        .mark_i       (mark_c),
        .mark_preg_i  (slot_d_q.pd_new),
        .mark_tag_i   (slot_d_q.rob_tag),
        .wake_valid_i (wake_valid),
        .wake_preg_i  (wake_preg),
        .flush_i      (mispredict),
        .flush_tag_i  (mispredict_tag),
        .rob_head_i   (rob_head),
        .rd_ps1_i     (slot_d_q.ps1),
        .rd_ps2_i     (slot_d_q.ps2),
        .ps1_rdy_c_o  (ps1_rdy_c),
        .ps2_rdy_c_o  (ps2_rdy_c)
    );

    // Allocation outputs: quiet while the slot is empty, pulses only on drain.
    always_comb begin
        rs_alloc_valid  = '0;
        rs_alloc_data   = '0;
        rs_ps1_rdy      = 1'b0;
        rs_ps2_rdy      = 1'b0;
        lsq_alloc_valid = 1'b0;
        lsq_rob_tag     = '0;
        lsq_pc          = '0;
        if (slot_v_q) begin
            rs_alloc_data = slot_d_q;
            rs_ps1_rdy    = ps1_rdy_c;
            rs_ps2_rdy    = ps2_rdy_c;
        end
        if (drain_c) begin
            rs_alloc_valid = chan_sel_c;
            if (slot_mem_c) begin
                lsq_alloc_valid = 1'b1;
                lsq_rob_tag     = slot_d_q.rob_tag;
                lsq_pc          = slot_d_q.pc;
            end
        end
    end

endmodule

// File: tb/tb_dispatch_stage_n.sv
// Bench for dispatch_stage_n: directed scenarios with literal expectations,
// then random traffic, all shadowed by an instruction-level model.
module tb_dispatch_stage_n;
    import dispatch_stage_n_pkg::*;

    localparam int NFU  = 3;
    localparam int MFU  = 3;
    localparam int NWK  = 3;
    localparam int ROBN = 32;

    logic                    clk;
    logic                    reset;
    logic                    valid_in;
    rename_data              data_in;
    logic                    ready_in;
    logic                    rob_full;
    logic [ROB_W-1:0]        rob_head;
    logic                    lsq_full_in;
    logic                    mispredict;
    logic [ROB_W-1:0]        mispredict_tag;
    logic [NWK-1:0]          wake_valid;
    logic [NWK*PREG_W-1:0]   wake_preg;
    logic [NFU-1:0]          rs_full;
    logic [NFU-1:0]          rs_alloc_valid;
    rename_data              rs_alloc_data;
    logic                    rs_ps1_rdy;
    logic                    rs_ps2_rdy;
    logic                    lsq_alloc_valid;
    logic [ROB_W-1:0]        lsq_rob_tag;
    logic [PC_W-1:0]         lsq_pc;

    int checks = 0;
    int errors = 0;

    dispatch_stage_n #(.NUM_FU(NFU), .MEM_FU(MFU), .NUM_WAKE(NWK)) dut (
        .clk(clk), .reset(reset), .valid_in(valid_in), .data_in(data_in),
        .ready_in(ready_in), .rob_full(rob_full), .rob_head(rob_head),
        .lsq_full_in(lsq_full_in), .mispredict(mispredict),
        .mispredict_tag(mispredict_tag), .wake_valid(wake_valid),
        .wake_preg(wake_preg), .rs_full(rs_full),
        .rs_alloc_valid(rs_alloc_valid), .rs_alloc_data(rs_alloc_data),
        .rs_ps1_rdy(rs_ps1_rdy), .rs_ps2_rdy(rs_ps2_rdy),
        .lsq_alloc_valid(lsq_alloc_valid), .lsq_rob_tag(lsq_rob_tag),
        .lsq_pc(lsq_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic rename_data mk(input int fu, input logic [6:0] opc, input int pd,
                                      input int s1, input int s2, input int tag, input int pc);
        rename_data r;
        r.fu      = FU_W'(fu);
        r.Opcode  = opc;
        r.pd_new  = PREG_W'(pd);
        r.ps1     = PREG_W'(s1);
        r.ps2     = PREG_W'(s2);
        r.rob_tag = ROB_W'(tag);
        r.pc      = PC_W'(pc);
        return r;
    endfunction

    // ---------------- instruction-level model ----------------
    bit         m_busy [NUM_PREG];
    int         m_tag  [NUM_PREG];
    bit         m_sv;
    rename_data m_sd;

    function automatic int wk(input int i);
        return int'(wake_preg[i*PREG_W +: PREG_W]);
    endfunction

    function automatic bit m_ready(input int p);
        if (p == 0 || !m_busy[p]) return 1'b1;
        for (int i = 0; i < NWK; i++) if (wake_valid[i] && wk(i) == p) return 1'b1;
        return 1'b0;
    endfunction

    // Compare DUT against the model mid-cycle, then advance the model across the next edge.
    always @(negedge clk) begin
        int fu;
        bit ldst, blocked, e_drain, e_ready, e_lsq;
        logic [NFU-1:0] e_alloc;
        int mage;
        if (reset) begin
            for (int p = 0; p < NUM_PREG; p++) begin m_busy[p] = 1'b0; m_tag[p] = 0; end
            m_sv = 1'b0;
            m_sd = '0;
        end else begin
            fu      = int'(m_sd.fu);
            ldst    = (m_sd.Opcode == OPC_LOAD) || (m_sd.Opcode == OPC_STORE);
            blocked = (fu >= 1 && fu <= NFU && rs_full[fu-1]) || (fu == MFU && ldst && lsq_full_in);
            e_drain = m_sv && !mispredict && !blocked;
            e_ready = mispredict || (!rob_full && (!m_sv || e_drain));
            e_alloc = '0;
            if (e_drain && fu >= 1 && fu <= NFU) e_alloc[fu-1] = 1'b1;
            e_lsq   = e_drain && fu == MFU && ldst;

            chk("ready_in", ready_in, e_ready);
            chk("rs_alloc_valid", rs_alloc_valid, e_alloc);
            chk("lsq_alloc_valid", lsq_alloc_valid, e_lsq);
            chk("lsq_rob_tag", lsq_rob_tag, e_lsq ? m_sd.rob_tag : '0);
            chk("lsq_pc", lsq_pc, e_lsq ? m_sd.pc : '0);
            if (!m_sv) begin
                chk("idle_data", rs_alloc_data, '0);
                chk("idle_ps1_rdy", rs_ps1_rdy, 1'b0);
                chk("idle_ps2_rdy", rs_ps2_rdy, 1'b0);
            end
            if (e_drain) begin
                chk("rs_alloc_data", rs_alloc_data, m_sd);
                chk("rs_ps1_rdy", rs_ps1_rdy, m_ready(int'(m_sd.ps1)));
                chk("rs_ps2_rdy", rs_ps2_rdy, m_ready(int'(m_sd.ps2)));
            end

            for (int i = 0; i < NWK; i++) if (wake_valid[i]) m_busy[wk(i)] = 1'b0;
            if (mispredict) begin
                mage = (int'(mispredict_tag) - int'(rob_head) + ROBN) % ROBN;
                for (int p = 0; p < NUM_PREG; p++)
                    if ((m_tag[p] - int'(rob_head) + ROBN) % ROBN > mage) m_busy[p] = 1'b0;
            end
            if (e_drain && m_sd.pd_new != 0 && m_sd.Opcode != OPC_STORE && m_sd.Opcode != OPC_BRANCH) begin
                m_busy[m_sd.pd_new] = 1'b1;
                m_tag[m_sd.pd_new]  = int'(m_sd.rob_tag);
            end
            if (mispredict) m_sv = 1'b0;
            else if (valid_in && e_ready) begin m_sv = 1'b1; m_sd = data_in; end
            else if (e_drain) m_sv = 1'b0;
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        valid_in = 1'b0; data_in = '0; rob_full = 1'b0; rob_head = '0;
        lsq_full_in = 1'b0; mispredict = 1'b0; mispredict_tag = '0;
        wake_valid = '0; wake_preg = '0; rs_full = '0;
    endtask

    logic [6:0] opcs [5];

    initial begin
        opcs[0] = OPC_OP; opcs[1] = OPC_LOAD; opcs[2] = OPC_STORE;
        opcs[3] = OPC_BRANCH; opcs[4] = OPC_JALR;
        quiet();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // ALU producer then dependent consumer
        valid_in = 1'b1; data_in = mk(1, OPC_OP, 40, 0, 0, 3, 'h100);
        @(negedge clk); chk("s1_ready", ready_in, 1'b1); chk("s1_empty", rs_alloc_valid, 3'b000);
        tick(); data_in = mk(2, OPC_OP, 41, 40, 0, 4, 'h104);
        @(negedge clk); chk("s1_alloc", rs_alloc_valid, 3'b001); chk("s1_pd", rs_alloc_data.pd_new, 7'd40);
        tick(); valid_in = 1'b0;
        @(negedge clk); chk("s1_cons_alloc", rs_alloc_valid, 3'b010); chk("s1_cons_rdy", rs_ps1_rdy, 1'b0);
        tick();

        // Branch held by full RS channel 1
        valid_in = 1'b1; data_in = mk(2, OPC_BRANCH, 0, 5, 6, 8, 'h200);
        tick(); rs_full = 3'b010; data_in = mk(1, OPC_OP, 7, 0, 0, 9, 'h204);
        @(negedge clk); chk("s2_ready", ready_in, 1'b0); chk("s2_hold", rs_alloc_valid, 3'b000);
        tick();
        @(negedge clk); chk("s2_hold2", rs_alloc_valid, 3'b000); chk("s2_opc", rs_alloc_data.Opcode, OPC_BRANCH);
        tick(); rs_full = '0; valid_in = 1'b0;
        @(negedge clk); chk("s2_release", rs_alloc_valid, 3'b010);
        tick();

        // Load blocked by LSQ full, then released
        valid_in = 1'b1; data_in = mk(3, OPC_LOAD, 20, 1, 0, 7, 'h1000);
        tick(); valid_in = 1'b0; lsq_full_in = 1'b1;
        @(negedge clk); chk("s3_block_rs", rs_alloc_valid, 3'b000); chk("s3_block_lsq", lsq_alloc_valid, 1'b0);
        tick(); lsq_full_in = 1'b0;
        @(negedge clk);
        chk("s3_rs", rs_alloc_valid, 3'b100); chk("s3_lsq", lsq_alloc_valid, 1'b1);
        chk("s3_tag", lsq_rob_tag, 5'd7); chk("s3_pc", lsq_pc, 32'h1000);
        tick();

        // Same-cycle wakeup bypass on ps2
        valid_in = 1'b1; data_in = mk(1, OPC_OP, 17, 0, 0, 10, 0);
        tick(); data_in = mk(1, OPC_OP, 0, 0, 17, 11, 0);
        tick(); data_in = mk(1, OPC_OP, 0, 0, 17, 12, 0);
        wake_valid = 3'b100; wake_preg[2*PREG_W +: PREG_W] = 7'd17;
        @(negedge clk); chk("s4_bypass", rs_ps2_rdy, 1'b1);
        tick(); valid_in = 1'b0; wake_valid = '0;
        @(negedge clk); chk("s4_cleared", rs_ps2_rdy, 1'b1);
        tick();

        // Selective flush with ROB wrap
        rob_head = 5'd30;
        valid_in = 1'b1; data_in = mk(1, OPC_OP, 50, 0, 0, 31, 0);
        tick(); data_in = mk(1, OPC_OP, 51, 0, 0, 2, 0);
        tick(); data_in = mk(1, OPC_OP, 52, 0, 0, 5, 0);
        tick(); data_in = mk(0, OPC_OP, 0, 0, 0, 6, 0);
        tick(); mispredict = 1'b1; mispredict_tag = 5'd1; data_in = mk(1, OPC_OP, 60, 0, 0, 7, 0);
        @(negedge clk); chk("s5_ready", ready_in, 1'b1); chk("s5_noalloc", rs_alloc_valid, 3'b000);
        tick(); mispredict = 1'b0; data_in = mk(1, OPC_OP, 0, 50, 51, 9, 0);
        @(negedge clk); chk("s5_slot_clear", rs_alloc_valid, 3'b000); chk("s5_data_clear", rs_alloc_data, '0);
        tick(); data_in = mk(1, OPC_OP, 0, 52, 0, 10, 0);
        @(negedge clk); chk("s5_older_busy", rs_ps1_rdy, 1'b0); chk("s5_younger_clr", rs_ps2_rdy, 1'b1);
        tick(); valid_in = 1'b0;
        @(negedge clk); chk("s5_wrap_clr", rs_ps1_rdy, 1'b1);
        tick(); quiet();

        // Store does not mark; mid-stream reset clears everything
        valid_in = 1'b1; data_in = mk(3, OPC_STORE, 9, 1, 2, 11, 'h300);
        tick(); data_in = mk(1, OPC_OP, 0, 9, 0, 12, 0);
        @(negedge clk); chk("s6_st_rs", rs_alloc_valid, 3'b100); chk("s6_st_lsq", lsq_alloc_valid, 1'b1);
        tick(); data_in = mk(1, OPC_OP, 60, 0, 0, 13, 0);
        @(negedge clk); chk("s6_no_mark", rs_ps1_rdy, 1'b1);
        tick(); data_in = mk(2, OPC_OP, 61, 0, 0, 14, 0);
        @(negedge clk); chk("s6_p60", rs_alloc_valid, 3'b001);
        tick(); valid_in = 1'b0; reset = 1'b1;
        tick(); reset = 1'b0;
        @(negedge clk);
        chk("s6_rst_alloc", rs_alloc_valid, 3'b000); chk("s6_rst_data", rs_alloc_data, '0);
        chk("s6_rst_lsq", lsq_alloc_valid, 1'b0); chk("s6_rst_ready", ready_in, 1'b1);
        valid_in = 1'b1; data_in = mk(1, OPC_OP, 0, 60, 61, 15, 0);
        tick(); valid_in = 1'b0;
        @(negedge clk); chk("s6_table_clr1", rs_ps1_rdy, 1'b1); chk("s6_table_clr2", rs_ps2_rdy, 1'b1);
        tick(); quiet();

        // Random traffic against the model
        for (int n = 0; n < 3000; n++) begin
            valid_in       = ($urandom_range(0, 3) != 0);
            data_in        = mk($urandom_range(0, 3), opcs[$urandom_range(0, 4)],
                                $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15),
                                $urandom_range(0, 31), $urandom);
            rob_full       = ($urandom_range(0, 9) == 0);
            rob_head       = ROB_W'($urandom_range(0, 31));
            lsq_full_in    = ($urandom_range(0, 3) == 0);
            mispredict     = ($urandom_range(0, 15) == 0);
            mispredict_tag = ROB_W'($urandom_range(0, 31));
            for (int i = 0; i < NFU; i++) rs_full[i] = ($urandom_range(0, 3) == 0);
            for (int i = 0; i < NWK; i++) begin
                wake_valid[i] = ($urandom_range(0, 9) < 3);
                wake_preg[i*PREG_W +: PREG_W] = PREG_W'($urandom_range(0, 15));
            end
            reset = ($urandom_range(0, 499) == 0);
            tick();
        end
        reset = 1'b0;
        quiet();
        tick();
        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
